// File: rtl/in_fm_rd_ctrl_pkg.sv
// Shared definitions for the feature-map / weight buffer read controllers:
// sequencer state encoding, address-walk deltas and per-tile issue count.
package in_fm_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // Counter width able to hold 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Address step when only the column loop advances.
  function automatic int delta_c();
    return 1;
  endfunction

  // Column loop wraps, row loop advances: jump to the next row start.
  function automatic int delta_r(input int tc, input int k);
    return tc - (tc - k);
  endfunction

  // Row and column loops wrap, kernel column advances.
  function automatic int delta_j(input int tr, input int tc, input int k);
    return 1 - (tr - k) * tc - (tc - k);
  endfunction

  // Kernel column wraps too, kernel row advances.
  function automatic int delta_i(input int tr, input int tc, input int k);
    return 1 - (tr - k) * tc;
  endfunction

  // Kernel row wraps too, next channel slice: last word of a slice to
  // the first word of the next one.
  function automatic int delta_p(input int tr, input int tc);
    return tr * tc - ((tr - 1) * tc + (tc - 1));
  endfunction

  // Number of read issues for one tile.
  function automatic int issue_count(input int tm, input int x, input int tr,
                                     input int tc, input int k);
    return (tm / x) * k * k * (tr - k + 1) * (tc - k + 1);
  endfunction

endpackage

// File: rtl/in_fm_rd_ctrl_cnt.sv
// Generic wrapping loop counter: counts 0..MAX on ena, synchronous clear.
module in_fm_rd_ctrl_cnt #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ena,
  output logic [W-1:0] cnt
);

  // Count register; wraps to zero after reaching MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ena) begin
      if (cnt == W'(MAX)) cnt <= '0;
      else                cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/in_fm_rd_ctrl.sv
// Input feature-map buffer read sequencer: walks the p/i/j/r/c convolution
// loop nest with chained counters, keeps a running address updated by
// precomputed deltas and emits valid/tags one cycle after each issue.
module in_fm_rd_ctrl
  import in_fm_rd_ctrl_pkg::*;
#(
  parameter int AW = 16,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int K  = 3,
  parameter int X  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_start,
  input  logic                 rd_ready,
  output logic [AW-1:0]        rd_addr0,
  output logic [AW-1:0]        rd_addr1,
  output logic [AW-1:0]        rd_addr2,
  output logic [AW-1:0]        rd_addr3,
  output logic                 rd_data_vld,
  output logic [$clog2(K)-1:0] kr,
  output logic [$clog2(K)-1:0] kc,
  output logic                 acc_first,
  output logic                 acc_last,
  output logic                 rd_busy,
  output logic                 rd_done
);

  localparam int KW    = $clog2(K);
  localparam int MAX_C = Tc - K;
  localparam int MAX_R = Tr - K;
  localparam int MAX_J = K - 1;
  localparam int MAX_I = K - 1;
  localparam int MAX_P = Tm / X - 1;
  localparam int WC    = cnt_w(MAX_C);
  localparam int WR    = cnt_w(MAX_R);
  localparam int WP    = cnt_w(MAX_P);

  // Per-loop address steps, two's complement so negative steps wrap mod 2^AW.
  localparam logic [AW-1:0] D_C = AW'(delta_c());
  localparam logic [AW-1:0] D_R = AW'(delta_r(Tc, K));
  localparam logic [AW-1:0] D_J = AW'(delta_j(Tr, Tc, K));
  localparam logic [AW-1:0] D_I = AW'(delta_i(Tr, Tc, K));
  localparam logic [AW-1:0] D_P = AW'(delta_p(Tr, Tc));

  rd_state_e state, state_nxt;

  logic          issue;
  logic          clr;
  logic [WC-1:0] cnt_c;
  logic [WR-1:0] cnt_r;
  logic [KW-1:0] cnt_j;
  logic [KW-1:0] cnt_i;
  logic [WP-1:0] cnt_p;
  logic          at_c, at_r, at_j, at_i, at_p;
  logic          ena_r, ena_j, ena_i, ena_p;
  logic          last_tuple;
  logic [AW-1:0] addr;

  assign clr = (state == ST_IDLE);

  assign at_c = (cnt_c == WC'(MAX_C));
  assign at_r = (cnt_r == WR'(MAX_R));
  assign at_j = (cnt_j == KW'(MAX_J));
  assign at_i = (cnt_i == KW'(MAX_I));
  assign at_p = (cnt_p == WP'(MAX_P));

  // Carry chain: an outer loop advances only when every inner loop wraps.
  assign ena_r      = issue & at_c;
  assign ena_j      = ena_r & at_r;
  assign ena_i      = ena_j & at_j;
  assign ena_p      = ena_i & at_i;
  assign last_tuple = at_c & at_r & at_j & at_i & at_p;

  in_fm_rd_ctrl_cnt #(.MAX(MAX_C), .W(WC)) u_cnt_c (
    .clk(clk), .rst(rst), .clr(clr), .ena(issue), .cnt(cnt_c));
  in_fm_rd_ctrl_cnt #(.MAX(MAX_R), .W(WR)) u_cnt_r (
    .clk(clk), .rst(rst), .clr(clr), .ena(ena_r), .cnt(cnt_r));
  in_fm_rd_ctrl_cnt #(.MAX(MAX_J), .W(KW)) u_cnt_j (
    .clk(clk), .rst(rst), .clr(clr), .ena(ena_j), .cnt(cnt_j));
  in_fm_rd_ctrl_cnt #(.MAX(MAX_I), .W(KW)) u_cnt_i (
    .clk(clk), .rst(rst), .clr(clr), .ena(ena_i), .cnt(cnt_i));
  in_fm_rd_ctrl_cnt #(.MAX(MAX_P), .W(WP)) u_cnt_p (
    .clk(clk), .rst(rst), .clr(clr), .ena(ena_p), .cnt(cnt_p));

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and issue decode.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE:  if (rd_start) state_nxt = ST_RUN;
      ST_RUN: begin
        issue = rd_ready;
        if (rd_ready && last_tuple) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Running address: the outermost advancing loop picks the step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (issue) begin
      if (ena_p && at_p) addr <= '0;
      else if (ena_p)    addr <= addr + D_P;
      else if (ena_i)    addr <= addr + D_I;
      else if (ena_j)    addr <= addr + D_J;
      else if (ena_r)    addr <= addr + D_R;
      else               addr <= addr + D_C;
    end
  end

  // Valid strobe and tags delayed one cycle to line up with bank read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_vld <= 1'b0;
      kr          <= '0;
      kc          <= '0;
      acc_first   <= 1'b0;
      acc_last    <= 1'b0;
    end else begin
      rd_data_vld <= issue;
      kr          <= issue ? cnt_i : '0;
      kc          <= issue ? cnt_j : '0;
      acc_first   <= issue && (cnt_p == '0) && (cnt_i == '0) && (cnt_j == '0);
      acc_last    <= issue && at_p && at_i && at_j;
    end
  end

  assign rd_addr0 = addr;
  assign rd_addr1 = addr;
  assign rd_addr2 = addr;
  assign rd_addr3 = addr;
  assign rd_busy  = (state != ST_IDLE);
  assign rd_done  = (state == ST_DONE);

endmodule
